// File: rtl/fifo_burst_writer_if.sv
// Handshake and parameter bundle between the burst writer and its
// surroundings (command source, FIFO write port, status consumers).
interface fifo_burst_writer_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [7:0]        burst_len;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] step;
    logic              w_full;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err_start;
    logic [CNT_W-1:0]  word_count;

    // Writer side: takes commands and the full flag, drives the FIFO strobe.
    modport master (
        input  start, burst_len, base, step, w_full,
        output wr_en, wr_data, busy, done, err_start, word_count
    );

    // Environment side: issues commands and watches the write port.
    modport slave (
        output start, burst_len, base, step, w_full,
        input  wr_en, wr_data, busy, done, err_start, word_count
    );
endinterface

// File: rtl/fifo_burst_writer.sv
// Commanded burst producer for the async FIFO write port: header word
// (length), arithmetic payload, XOR checksum. Stalls cleanly on w_full.
module fifo_burst_writer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic clk_wr,
    input  logic reset,
    fifo_burst_writer_if.master bus
);
    typedef enum logic [2:0] {IDLE, HDR, PAY, CSUM, FIN} state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        idx_q, idx_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [CNT_W-1:0]  cnt_q;

    logic word_st;
    logic accept;
    logic [DATA_W-1:0] acc_nxt;

    assign word_st = (state_q == HDR) || (state_q == PAY) || (state_q == CSUM);
    assign accept  = word_st && !bus.w_full;
    // Accumulator including the word currently being accepted; the checksum
    // word is loaded from this so it covers the last payload word too.
    assign acc_nxt = acc_q ^ wr_data_q;

    // Next-state and datapath: wr_data_q always holds the word to present,
    // so it only advances on acceptance and is frozen during a stall.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        base_d    = base_q;
        step_d    = step_q;
        acc_d     = acc_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d     = bus.burst_len;
                    base_d    = bus.base;
                    step_d    = bus.step;
                    idx_d     = '0;
                    acc_d     = '0;
                    wr_data_d = DATA_W'(bus.burst_len);
                    state_d   = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    acc_d = acc_nxt;
                    if (len_q != 8'd0) begin
                        wr_data_d = base_q;
                        state_d   = PAY;
                    end else begin
                        wr_data_d = acc_nxt;
                        state_d   = CSUM;
                    end
                end
            end
            PAY: begin
                if (accept) begin
                    acc_d = acc_nxt;
                    idx_d = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) begin
                        wr_data_d = acc_nxt;
                        state_d   = CSUM;
                    end else begin
                        wr_data_d = wr_data_q + step_q;
                    end
                end
            end
            CSUM: begin
                if (accept) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_wr or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            base_q    <= '0;
            step_q    <= '0;
            acc_q     <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            step_q    <= step_d;
            acc_q     <= acc_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Lifetime count of words written into the FIFO.
    always_ff @(posedge clk_wr or posedge reset) begin
        if (reset) cnt_q <= '0;
        else if (accept) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.wr_en      = accept;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == FIN);
    assign bus.err_start  = bus.start && (state_q != IDLE);
    assign bus.word_count = cnt_q;
endmodule

// File: tb/tb_fifo_burst_writer.sv
// Randomized bench for fifo_burst_writer: each frame is compared against a
// list of words built straight from the frame rules (length, base+i*step,
// XOR of all previous words).
module tb_fifo_burst_writer;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   strobes = 0;

    fifo_burst_writer_if #(.DATA_W(8), .CNT_W(16)) bus ();

    fifo_burst_writer #(.DATA_W(8), .CNT_W(16)) dut (
        .clk_wr (clk),
        .reset  (reset),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode: 0 never full, 1 random full, 2 full on cycles 3..7 after start.
    // err_at: cycle on which a second (illegal) start is pulsed, 0 = none.
    task automatic run_burst(input int n, input logic [7:0] b, input logic [7:0] s,
                             input int mode, input int err_at);
        logic [7:0] exp[$];
        logic [7:0] obs[$];
        logic [7:0] acc;
        logic [7:0] w;
        int cyc, stalls, errs;
        bit fin;
        exp.delete();
        obs.delete();
        exp.push_back(8'(n));
        acc = 8'(n);
        for (int i = 0; i < n; i++) begin
            w = 8'(32'(b) + i * 32'(s));
            exp.push_back(w);
            acc = acc ^ w;
        end
        exp.push_back(acc);

        @(posedge clk); #1;
        bus.start = 1'b1; bus.burst_len = 8'(n); bus.base = b; bus.step = s;
        bus.w_full = 1'b0;
        @(posedge clk); #1;
        // Scramble inputs after the start edge: the frame must use latched values.
        bus.burst_len = 8'($urandom); bus.base = 8'($urandom); bus.step = 8'($urandom);
        cyc = 0; stalls = 0; errs = 0; fin = 0;
        while (cyc < 2000) begin
            cyc++;
            case (mode)
                1:       bus.w_full = ($urandom_range(0, 2) == 0);
                2:       bus.w_full = (cyc >= 3 && cyc <= 7);
                default: bus.w_full = 1'b0;
            endcase
            bus.start = (cyc == err_at);
            @(negedge clk);
            if (bus.err_start) errs++;
            if (bus.done) begin
                fin = 1;
                chk("wr_en_fin", 32'(bus.wr_en), 0);
                break;
            end
            if (bus.w_full) begin
                stalls++;
                chk("wr_en_stall", 32'(bus.wr_en), 0);
                if (obs.size() < exp.size())
                    chk("hold_data", 32'(bus.wr_data), 32'(exp[obs.size()]));
            end
            if (bus.wr_en) begin
                obs.push_back(bus.wr_data);
                strobes++;
            end
            @(posedge clk); #1;
        end
        chk("done_seen", 32'(fin), 1);
        if (fin) begin
            chk("latency", cyc, n + 3 + stalls);
            chk("err_pulses", errs, (err_at > 0) ? 1 : 0);
            chk("word_num", obs.size(), exp.size());
            for (int i = 0; i < exp.size() && i < obs.size(); i++)
                chk($sformatf("word%0d", i), 32'(obs[i]), 32'(exp[i]));
            @(posedge clk); #1;
            bus.start = 1'b0; bus.w_full = 1'b0;
            @(negedge clk);
            chk("idle_busy", 32'(bus.busy), 0);
            chk("idle_done", 32'(bus.done), 0);
            chk("idle_wr_en", 32'(bus.wr_en), 0);
            chk("word_count", 32'(bus.word_count), 32'(16'(strobes)));
        end
        bus.start = 1'b0;
        bus.w_full = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.burst_len = '0; bus.base = '0; bus.step = '0; bus.w_full = 1'b0;
        #12;
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err_start), 0);
        chk("rst_count", 32'(bus.word_count), 0);
        @(negedge clk); reset = 1'b0;

        run_burst(4, 8'h00, 8'h04, 0, 0);
        run_burst(0, 8'h55, 8'h11, 0, 0);
        run_burst(3, 8'h10, 8'h01, 2, 0);
        run_burst(3, 8'hF0, 8'h20, 0, 3);

        // Asynchronous reset in the middle of an N=10 payload.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.burst_len = 8'd10; bus.base = 8'h40; bus.step = 8'h03;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("pre_rst_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", 32'(bus.wr_en), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_count", 32'(bus.word_count), 0);
        chk("mid_rst_data", 32'(bus.wr_data), 0);
        strobes = 0;
        @(negedge clk); reset = 1'b0;
        run_burst(2, 8'h7E, 8'h81, 0, 0);

        // Random soak with random back-pressure.
        run_burst(255, 8'($urandom), 8'($urandom), 1, 0);
        for (int k = 0; k < 40; k++)
            run_burst($urandom_range(0, 24), 8'($urandom), 8'($urandom), 1,
                      (k % 5 == 0) ? 2 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
